// File: rtl/mac_dispatch_pkg.sv
// Shared parameters and FSM encoding for the mac spike dispatcher.
// Imported by mac_spike_dispatcher and weight_regfile.
package mac_dispatch_pkg;

    localparam int NUM_INPUTS = 4;
    localparam int WEIGHT_W   = 32;
    localparam int ID_W       = 2;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPATCH = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

endpackage

// File: rtl/weight_regfile.sv
// Per-input weight registers with one write port and a flat snapshot bus.
// Weight i appears at snapshot[WEIGHT_W*i +: WEIGHT_W].
module weight_regfile
    import mac_dispatch_pkg::*;
#(
    parameter int N  = NUM_INPUTS,
    parameter int W  = WEIGHT_W,
    parameter int AW = ID_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [W-1:0]   wr_data,
    output logic [N*W-1:0] snapshot
);

    logic [W-1:0] regs [N];

    // Weight storage; a write lands at the clock edge, so a same-cycle reader sees the old value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign snapshot[W*g +: W] = regs[g];
    end

endmodule

// File: rtl/mac_spike_dispatcher.sv
// Collects spike IDs per timestep, dispatches them with a weight snapshot to the mac and captures its sum.
// Optional SPIKE_COUNT_EN adds spike_count[7:0]: accepted events per timestep, saturating.
module mac_spike_dispatcher
    import mac_dispatch_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spk_valid,
    input  logic [ID_W-1:0]              spk_id,
    output logic                         spk_ready,
    input  logic                         timestep_tick,
    input  logic                         w_wr_en,
    input  logic [ID_W-1:0]              w_wr_addr,
    input  logic [WEIGHT_W-1:0]          w_wr_data,
    output logic [NUM_INPUTS-1:0]        spike_in,
    output logic [NUM_INPUTS*WEIGHT_W-1:0] weights_in,
    output logic                         mac_valid,
    input  logic [WEIGHT_W-1:0]          mac_result,
    output logic [WEIGHT_W-1:0]          result,
    output logic                         result_valid,
`ifdef SPIKE_COUNT_EN
    output logic [7:0]                   spike_count,
`endif
    output logic                         tick_drop
);

    state_t state, state_nxt;
    logic [NUM_INPUTS-1:0] pending, new_mask;
    logic [NUM_INPUTS*WEIGHT_W-1:0] snap;
    logic accept, start;

    weight_regfile u_wrf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_wr_en),
        .wr_addr  (w_wr_addr),
        .wr_data  (w_wr_data),
        .snapshot (snap)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    // Next state, handshake and dispatch strobes
    always_comb begin
        state_nxt = state;
        spk_ready = 1'b0;
        start     = 1'b0;
        unique case (state)
            COLLECT: begin
                spk_ready = 1'b1;
                if (timestep_tick) begin
                    start     = 1'b1;
                    state_nxt = DISPATCH;
                end
            end
            DISPATCH: state_nxt = CAPTURE;
            CAPTURE:  state_nxt = COLLECT;
            default:  state_nxt = COLLECT;
        endcase
    end

    assign accept   = spk_valid && spk_ready;
    assign new_mask = pending |
        (accept ? (NUM_INPUTS'(1) << spk_id) : '0);

    // Spike accumulation, dispatch registers, result capture and drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            spike_in     <= '0;
            weights_in   <= '0;
            mac_valid    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            tick_drop    <= 1'b0;
        end else begin
            result_valid <= (state == DISPATCH);
            if (start) begin
                spike_in   <= new_mask;
                weights_in <= snap;
                mac_valid  <= 1'b1;
                pending    <= '0;
            end else begin
                pending <= new_mask;
            end
            if (state == DISPATCH) begin
                mac_valid <= 1'b0;
                result    <= mac_result;
            end
            if (timestep_tick && state != COLLECT) tick_drop <= 1'b1;
        end
    end

`ifdef SPIKE_COUNT_EN
    logic [7:0] cnt, cnt_nxt;

    assign cnt_nxt = (accept && cnt != 8'hFF) ? cnt + 8'd1 : cnt;

    // Per-timestep event counter, latched and cleared at dispatch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            spike_count <= '0;
        end else if (start) begin
            cnt         <= '0;
            spike_count <= cnt_nxt;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_mac_spike_dispatcher.sv
// Self-checking bench for mac_spike_dispatcher with a behavioural mac and reference model.
// Define SPIKE_COUNT_EN for both RTL and bench to exercise the optional counter.
module tb_mac_spike_dispatcher;

    logic        clk = 0;
    logic        reset;
    logic        spk_valid;
    logic [1:0]  spk_id;
    logic        spk_ready;
    logic        timestep_tick;
    logic        w_wr_en;
    logic [1:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [3:0]  spike_in;
    logic [127:0] weights_in;
    logic        mac_valid;
    logic [31:0] mac_result;
    logic [31:0] result;
    logic        result_valid;
    logic        tick_drop;
`ifdef SPIKE_COUNT_EN
    logic [7:0]  spike_count;
`endif

    int checks = 0;
    int errors = 0;

    // reference state: weights and pending spike set
    logic [31:0] mw [4];
    bit          mp [4];
    int          mcnt;

    always #5 clk = ~clk;

    // behavioural mac: sum of weights whose spike bit is set, modulo 2^32
    always_comb begin
        mac_result = '0;
        for (int i = 0; i < 4; i++)
            if (spike_in[i]) mac_result = mac_result + weights_in[32*i +: 32];
    end

    mac_spike_dispatcher dut (
        .clk           (clk),
        .reset         (reset),
        .spk_valid     (spk_valid),
        .spk_id        (spk_id),
        .spk_ready     (spk_ready),
        .timestep_tick (timestep_tick),
        .w_wr_en       (w_wr_en),
        .w_wr_addr     (w_wr_addr),
        .w_wr_data     (w_wr_data),
        .spike_in      (spike_in),
        .weights_in    (weights_in),
        .mac_valid     (mac_valid),
        .mac_result    (mac_result),
        .result        (result),
        .result_valid  (result_valid),
`ifdef SPIKE_COUNT_EN
        .spike_count   (spike_count),
`endif
        .tick_drop     (tick_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        spk_valid = 0; spk_id = 0; timestep_tick = 0;
        w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0;
    endtask

    function automatic logic [31:0] model_sum(input logic [3:0] m);
        logic [31:0] s = 0;
        for (int i = 0; i < 4; i++) if (m[i]) s = s + mw[i];
        return s;
    endfunction

    function automatic logic [3:0] model_mask();
        logic [3:0] m = 0;
        for (int i = 0; i < 4; i++) m[i] = mp[i];
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin mw[i] = 0; mp[i] = 0; end
        mcnt = 0;
    endtask

    task automatic write_w(input int a, input logic [31:0] d);
        w_wr_en = 1; w_wr_addr = 2'(a); w_wr_data = d;
        step();
        w_wr_en = 0;
        mw[a] = d;
    endtask

    task automatic load_spec_weights();
        write_w(0, 64); write_w(1, 18321983); write_w(2, 5); write_w(3, 7);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        model_clear();
        #1;
        checks++; if (spk_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", spk_ready); end
        checks++; if (spike_in !== 4'b0) begin errors++; $display("FAIL reset_spike_in got %0h exp 0", spike_in); end
        checks++; if (mac_valid !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL reset_valids got %0b%0b exp 00", mac_valid, result_valid); end
        checks++; if (result !== 32'd0 || tick_drop !== 1'b0) begin errors++; $display("FAIL reset_result got %0h/%0b exp 0/0", result, tick_drop); end
        checks++; if (weights_in !== 128'd0) begin errors++; $display("FAIL reset_weights got %0h exp 0", weights_in); end
        step(); step();
        reset = 0;
        step();
    endtask

    task automatic test_basic();
        spk_valid = 1; spk_id = 0; step();
        spk_id = 1; step();
        spk_valid = 0; timestep_tick = 1; step();
        timestep_tick = 0;
        checks++; if (spike_in !== 4'b0011) begin errors++; $display("FAIL basic_spike_in got %b exp 0011", spike_in); end
        checks++; if (mac_valid !== 1'b1) begin errors++; $display("FAIL basic_mac_valid got %0b exp 1", mac_valid); end
        checks++; if (spk_ready !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL basic_t1 ready/rv got %0b/%0b exp 0/0", spk_ready, result_valid); end
        step();
        checks++; if (result !== 32'd18322047) begin errors++; $display("FAIL basic_result got %0d exp 18322047", result); end
        checks++; if (result_valid !== 1'b1 || mac_valid !== 1'b0 || spk_ready !== 1'b0) begin errors++; $display("FAIL basic_t2 rv/mv/rdy got %0b/%0b/%0b exp 1/0/0", result_valid, mac_valid, spk_ready); end
        step();
        checks++; if (result_valid !== 1'b0 || spk_ready !== 1'b1) begin errors++; $display("FAIL basic_t3 rv/rdy got %0b/%0b exp 0/1", result_valid, spk_ready); end
        checks++; if (result !== 32'd18322047 || spike_in !== 4'b0011) begin errors++; $display("FAIL basic_hold got %0d/%b exp 18322047/0011", result, spike_in); end
`ifdef SPIKE_COUNT_EN
        checks++; if (spike_count !== 8'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", spike_count); end
`endif
    endtask

    task automatic test_empty();
        timestep_tick = 1; step();
        timestep_tick = 0;
        checks++; if (spike_in !== 4'b0 || mac_valid !== 1'b1) begin errors++; $display("FAIL empty_t1 got %b/%0b exp 0000/1", spike_in, mac_valid); end
        step();
        checks++; if (result !== 32'd0 || result_valid !== 1'b1) begin errors++; $display("FAIL empty_t2 got %0d/%0b exp 0/1", result, result_valid); end
        step();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL empty_pulse got %0b exp 0", result_valid); end
    endtask

    task automatic test_same_cycle();
        spk_valid = 1; spk_id = 2; step();
        step();
        spk_id = 3; timestep_tick = 1; step();
        spk_valid = 0; timestep_tick = 0;
        checks++; if (spike_in !== 4'b1100) begin errors++; $display("FAIL same_spike_in got %b exp 1100", spike_in); end
        step();
        checks++; if (result !== 32'd12 || result_valid !== 1'b1) begin errors++; $display("FAIL same_result got %0d/%0b exp 12/1", result, result_valid); end
`ifdef SPIKE_COUNT_EN
        checks++; if (spike_count !== 8'd3) begin errors++; $display("FAIL same_count got %0d exp 3", spike_count); end
`endif
        step();
    endtask

    task automatic test_tick_drop();
        checks++; if (tick_drop !== 1'b0) begin errors++; $display("FAIL drop_pre got %0b exp 0", tick_drop); end
        timestep_tick = 1; step();
        checks++; if (spk_ready !== 1'b0) begin errors++; $display("FAIL drop_rdy_t1 got %0b exp 0", spk_ready); end
        step();
        timestep_tick = 0;
        checks++; if (spk_ready !== 1'b0 || result_valid !== 1'b1 || tick_drop !== 1'b1) begin errors++; $display("FAIL drop_t2 rdy/rv/drop got %0b/%0b/%0b exp 0/1/1", spk_ready, result_valid, tick_drop); end
        step();
        checks++; if (result_valid !== 1'b0 || mac_valid !== 1'b0 || spk_ready !== 1'b1) begin errors++; $display("FAIL drop_t3 rv/mv/rdy got %0b/%0b/%0b exp 0/0/1", result_valid, mac_valid, spk_ready); end
        step();
        checks++; if (result_valid !== 1'b0 || tick_drop !== 1'b1) begin errors++; $display("FAIL drop_t4 rv/drop got %0b/%0b exp 0/1", result_valid, tick_drop); end
    endtask

    task automatic test_write_tick();
        spk_valid = 1; spk_id = 0; timestep_tick = 1;
        w_wr_en = 1; w_wr_addr = 0; w_wr_data = 100;
        step();
        spk_valid = 0; timestep_tick = 0; w_wr_en = 0;
        step();
        checks++; if (result !== 32'd64) begin errors++; $display("FAIL wrtick_old got %0d exp 64", result); end
        step();
        mw[0] = 100;
        spk_valid = 1; spk_id = 0; timestep_tick = 1; step();
        spk_valid = 0; timestep_tick = 0; step();
        checks++; if (result !== 32'd100) begin errors++; $display("FAIL wrtick_new got %0d exp 100", result); end
        step();
    endtask

    task automatic test_reset_mid();
        spk_valid = 1; spk_id = 1; step();
        spk_valid = 0; timestep_tick = 1; step();
        timestep_tick = 0;
        reset = 1; #1;
        model_clear();
        checks++; if (spike_in !== 4'b0 || mac_valid !== 1'b0 || result !== 32'd0 || result_valid !== 1'b0 || tick_drop !== 1'b0) begin errors++; $display("FAIL rstmid_outs got %b/%0b/%0d/%0b/%0b exp 0", spike_in, mac_valid, result, result_valid, tick_drop); end
        step();
        reset = 0;
        step();
        checks++; if (spk_ready !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after rdy/rv got %0b/%0b exp 1/0", spk_ready, result_valid); end
        step();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_nopulse got %0b exp 0", result_valid); end
    endtask

    task automatic test_random();
        logic [3:0]  em;
        logic [31:0] es;
        int          wa;
        logic [31:0] wd;
        for (int i = 0; i < 4; i++) write_w(i, $urandom);
        for (int ts = 0; ts < 25; ts++) begin
            int n = $urandom_range(0, 5);
            mcnt = 0;
            for (int c = 0; c <= n; c++) begin
                spk_valid = 1'($urandom);
                spk_id = 2'($urandom);
                w_wr_en = ($urandom % 4 == 0);
                wa = $urandom_range(0, 3);
                wd = $urandom;
                w_wr_addr = 2'(wa); w_wr_data = wd;
                timestep_tick = (c == n);
                if (spk_valid) begin mp[spk_id] = 1; mcnt++; end
                em = model_mask();
                es = model_sum(em);
                step();
                if (w_wr_en) mw[wa] = wd;
            end
            idle_inputs();
            for (int i = 0; i < 4; i++) mp[i] = 0;
            checks++; if (spike_in !== em || mac_valid !== 1'b1) begin errors++; $display("FAIL rand%0d_spike_in got %b/%0b exp %b/1", ts, spike_in, mac_valid, em); end
            step();
            checks++; if (result !== es || result_valid !== 1'b1) begin errors++; $display("FAIL rand%0d_result got %0h/%0b exp %0h/1", ts, result, result_valid, es); end
`ifdef SPIKE_COUNT_EN
            checks++; if (spike_count !== 8'(mcnt)) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", ts, spike_count, mcnt); end
`endif
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        load_spec_weights();
        test_basic();
        test_empty();
        test_same_cycle();
        test_tick_drop();
        test_write_tick();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
